// File: rtl/dpram_sclk_be.sv
// ---------------------------------------------------------------------------
// dpram_sclk_be
//
// Single-clock simple dual-port RAM with one read port and one write port.
// Writes use per-byte lane enables. Read latency is set to 1 or 2 cycles by a
// parameter. A read and a write to the same address in the same cycle return
// either the byte-merged new word (bypass on) or the old word (bypass off).
// An optional clear sequencer writes zero to every word after reset, so the
// memory is in a known state in silicon and not only in simulation.
//
// Ports:
//   clk        single clock, all logic on the rising edge
//   rst        synchronous active-high reset (memory contents untouched)
//   raddr, re  read address / read request
//   waddr, we  write address / write request
//   wbe        byte-lane write enables, lane i = din[i*BYTE_WIDTH +: BYTE_WIDTH]
//   din        write data
//   dout       read data, forced to 0 whenever dvalid is low
//   dvalid     dout holds a read accepted READ_LATENCY cycles earlier
//   init_busy  clear sequence running; re/we are ignored while high
// ---------------------------------------------------------------------------
module dpram_sclk_be #(
    parameter int ADDR_WIDTH     = 9,
    parameter int DATA_WIDTH     = 16,
    parameter int BYTE_WIDTH     = 8,
    parameter int READ_LATENCY   = 1,
    parameter int ENABLE_BYPASS  = 1,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [ADDR_WIDTH-1:0]            raddr,
    input  logic                             re,
    input  logic [ADDR_WIDTH-1:0]            waddr,
    input  logic                             we,
    input  logic [DATA_WIDTH/BYTE_WIDTH-1:0] wbe,
    input  logic [DATA_WIDTH-1:0]            din,
    output logic [DATA_WIDTH-1:0]            dout,
    output logic                             dvalid,
    output logic                             init_busy
);

    localparam int NB    = DATA_WIDTH / BYTE_WIDTH;
    localparam int DEPTH = 1 << ADDR_WIDTH;

    // Reject configurations the datapath cannot express.
    if ((READ_LATENCY != 1) && (READ_LATENCY != 2)) begin : g_bad_latency
        $error("dpram_sclk_be: READ_LATENCY must be 1 or 2");
    end
    if ((DATA_WIDTH % BYTE_WIDTH) != 0) begin : g_bad_width
        $error("dpram_sclk_be: DATA_WIDTH must be a multiple of BYTE_WIDTH");
    end

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic                  busy;
    logic                  clr_we;
    logic [ADDR_WIDTH-1:0] clr_addr;
    logic                  rd_accept;
    logic                  wr_accept;

    // Requests only count when the memory is idle and not being reset.
    assign rd_accept = re && !busy && !rst;
    assign wr_accept = we && !busy && !rst;
    assign init_busy = busy;

    if (CLEAR_ON_RESET != 0) begin : g_clear
        typedef enum logic {CLEAR, RUN} clr_state_t;

        clr_state_t            state, state_next;
        logic [ADDR_WIDTH-1:0] count, count_next;

        // Reset always restarts the sweep from address 0, even mid-clear.
        always_ff @(posedge clk) begin
            if (rst) begin
                state <= CLEAR;
                count <= '0;
            end else begin
                state <= state_next;
                count <= count_next;
            end
        end

        // One word per cycle; leave CLEAR after the last address is written.
        always_comb begin
            state_next = state;
            count_next = count;
            if (state == CLEAR) begin
                count_next = count + 1'b1;
                if (&count) begin
                    state_next = RUN;
                end
            end
        end

        assign busy     = (state == CLEAR);
        assign clr_we   = (state == CLEAR) && !rst;
        assign clr_addr = count;
    end else begin : g_no_clear
        assign busy     = 1'b0;
        assign clr_we   = 1'b0;
        assign clr_addr = '0;
    end

    // Single physical write port shared by the clear sweep and user writes;
    // the two never overlap because user writes are blocked while busy.
    always_ff @(posedge clk) begin
        if (clr_we) begin
            mem[clr_addr] <= '0;
        end else if (wr_accept) begin
            for (int i = 0; i < NB; i++) begin
                if (wbe[i]) begin
                    mem[waddr][i*BYTE_WIDTH +: BYTE_WIDTH] <= din[i*BYTE_WIDTH +: BYTE_WIDTH];
                end
            end
        end
    end

    logic [DATA_WIDTH-1:0] rd_word;

    // Array read sees the pre-write word; bypass overlays enabled lanes of din.
    always_comb begin
        rd_word = mem[raddr];
        if ((ENABLE_BYPASS != 0) && wr_accept && (waddr == raddr)) begin
            for (int i = 0; i < NB; i++) begin
                if (wbe[i]) begin
                    rd_word[i*BYTE_WIDTH +: BYTE_WIDTH] = din[i*BYTE_WIDTH +: BYTE_WIDTH];
                end
            end
        end
    end

    logic                  s1_valid;
    logic [DATA_WIDTH-1:0] s1_data;
    logic                  out_valid;
    logic [DATA_WIDTH-1:0] out_data;

    // First read stage: capture the (possibly merged) word.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_data  <= '0;
        end else begin
            s1_valid <= rd_accept;
            s1_data  <= rd_accept ? rd_word : '0;
        end
    end

    if (READ_LATENCY == 2) begin : g_lat2
        logic                  s2_valid;
        logic [DATA_WIDTH-1:0] s2_data;

        // Output register; reset flushes anything still in flight.
        always_ff @(posedge clk) begin
            if (rst) begin
                s2_valid <= 1'b0;
                s2_data  <= '0;
            end else begin
                s2_valid <= s1_valid;
                s2_data  <= s1_data;
            end
        end

        assign out_valid = s2_valid;
        assign out_data  = s2_data;
    end else begin : g_lat1
        assign out_valid = s1_valid;
        assign out_data  = s1_data;
    end

    assign dvalid = out_valid;
    assign dout   = out_valid ? out_data : '0;

endmodule

// File: tb/tb_dpram_sclk_be.sv
// ---------------------------------------------------------------------------
// tb_dpram_sclk_be
//
// Drives two dpram_sclk_be instances (16 words x 16 bits) from one shared
// stimulus stream:
//   dut0: READ_LATENCY=1, ENABLE_BYPASS=1
//   dut1: READ_LATENCY=2, ENABLE_BYPASS=0
// A word-level model (array of words, remaining-clear count, per-edge read
// results) predicts busy/dvalid/dout for both every cycle. Directed sections
// add hand-computed literal expectations; a random section follows.
// ---------------------------------------------------------------------------
module tb_dpram_sclk_be;

    localparam int AW   = 4;
    localparam int DW   = 16;
    localparam int N    = 1 << AW;
    localparam int MAXE = 4096;

    logic          clk;
    logic          rst;
    logic [AW-1:0] raddr;
    logic          re;
    logic [AW-1:0] waddr;
    logic          we;
    logic [1:0]    wbe;
    logic [DW-1:0] din;

    logic [DW-1:0] dout0, dout1;
    logic          dvalid0, dvalid1;
    logic          busy0, busy1;

    int vectors    = 0;
    int miscompares = 0;

    dpram_sclk_be #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BYTE_WIDTH(8),
        .READ_LATENCY(1), .ENABLE_BYPASS(1), .CLEAR_ON_RESET(1)
    ) dut0 (
        .clk(clk), .rst(rst), .raddr(raddr), .re(re), .waddr(waddr), .we(we),
        .wbe(wbe), .din(din), .dout(dout0), .dvalid(dvalid0), .init_busy(busy0)
    );

    dpram_sclk_be #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BYTE_WIDTH(8),
        .READ_LATENCY(2), .ENABLE_BYPASS(0), .CLEAR_ON_RESET(1)
    ) dut1 (
        .clk(clk), .rst(rst), .raddr(raddr), .re(re), .waddr(waddr), .we(we),
        .wbe(wbe), .din(din), .dout(dout1), .dvalid(dvalid1), .init_busy(busy1)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s at %0t: actual=%h required=%h", name, $time, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [DW-1:0] mem_m [2][N];
    int            busy_left [2];
    bit            res_v [2][MAXE];
    logic [DW-1:0] res_d [2][MAXE];
    bit            rst_at [MAXE];
    int            edge_n  = 0;
    bit            started = 0;
    logic          exp_v [2];
    logic [DW-1:0] exp_d [2];
    logic          exp_busy [2];
    int            src;

    function automatic int lat(input int c);
        return (c == 0) ? 1 : 2;
    endfunction

    function automatic logic [DW-1:0] merge(input logic [DW-1:0] base, input logic [DW-1:0] nw,
                                            input logic [1:0] be);
        logic [DW-1:0] r;
        r = base;
        if (be[0]) r[7:0]  = nw[7:0];
        if (be[1]) r[15:8] = nw[15:8];
        return r;
    endfunction

    initial begin
        for (int c = 0; c < 2; c++) begin
            busy_left[c] = N;
            for (int a = 0; a < N; a++) mem_m[c][a] = '0;
        end
    end

    // Advance the model at every edge, then compare all outputs 1 time unit later.
    always @(posedge clk) begin
        if (edge_n >= MAXE) begin
            $display("[TB] FAIL edge_budget: actual=%0d required<%0d", edge_n, MAXE);
            $fatal(1, "[TB] edge budget exhausted");
        end
        rst_at[edge_n] = rst;
        for (int c = 0; c < 2; c++) begin
            if (!rst && busy_left[c] == 0 && re) begin
                res_v[c][edge_n] = 1'b1;
                if (c == 0 && we && waddr == raddr)
                    res_d[c][edge_n] = merge(mem_m[c][raddr], din, wbe);
                else
                    res_d[c][edge_n] = mem_m[c][raddr];
            end else begin
                res_v[c][edge_n] = 1'b0;
                res_d[c][edge_n] = '0;
            end

            if (rst) begin
                busy_left[c] = N;
            end else if (busy_left[c] > 0) begin
                mem_m[c][N - busy_left[c]] = '0;
                busy_left[c]--;
            end else if (we) begin
                mem_m[c][waddr] = merge(mem_m[c][waddr], din, wbe);
            end

            src = edge_n - lat(c) + 1;
            exp_v[c] = 1'b0;
            exp_d[c] = '0;
            if (src >= 0) begin
                exp_v[c] = res_v[c][src];
                for (int j = src + 1; j <= edge_n; j++)
                    if (rst_at[j]) exp_v[c] = 1'b0;
                if (exp_v[c]) exp_d[c] = res_d[c][src];
            end
            exp_busy[c] = (busy_left[c] > 0);
        end
        if (rst) started = 1;
        edge_n++;
        #1;
        if (started) begin
            check_output("busy0",   busy0,   exp_busy[0]);
            check_output("dvalid0", dvalid0, exp_v[0]);
            check_output("dout0",   dout0,   exp_d[0]);
            check_output("busy1",   busy1,   exp_busy[1]);
            check_output("dvalid1", dvalid1, exp_v[1]);
            check_output("dout1",   dout1,   exp_d[1]);
        end
    end

    // ---------------- stimulus ----------------
    task automatic apply_stimulus(input logic r_rst, input logic r_re, input logic [AW-1:0] r_raddr,
                                  input logic r_we, input logic [AW-1:0] r_waddr,
                                  input logic [1:0] r_wbe, input logic [DW-1:0] r_din);
        @(negedge clk);
        rst   = r_rst;
        re    = r_re;
        raddr = r_raddr;
        we    = r_we;
        waddr = r_waddr;
        wbe   = r_wbe;
        din   = r_din;
    endtask

    task automatic idle();
        apply_stimulus(1'b0, 1'b0, '0, 1'b0, '0, 2'b00, '0);
    endtask

    // Called at the negedge right after the reset edge; counts busy cycles.
    task automatic measure_clear(input string name, input bit hammer);
        int n0 = 0;
        int n1 = 0;
        for (int i = 0; i < 100; i++) begin
            if (!busy0 && !busy1) break;
            if (busy0) n0++;
            if (busy1) n1++;
            if (hammer) begin
                re    = 1'b1;
                we    = 1'b1;
                raddr = AW'($urandom_range(0, N-1));
                waddr = AW'($urandom_range(0, N-1));
                wbe   = 2'b11;
                din   = DW'($urandom);
            end
            @(negedge clk);
        end
        re = 1'b0;
        we = 1'b0;
        check_output({name, "_len0"}, n0, N);
        check_output({name, "_len1"}, n1, N);
    endtask

    // Single read with literal expectations: dut0 at +1, dut1 at +2.
    task automatic read_check(input logic [AW-1:0] a, input logic [DW-1:0] e0, input logic [DW-1:0] e1);
        apply_stimulus(1'b0, 1'b1, a, 1'b0, '0, 2'b00, '0);
        idle();
        check_output("lit_dvalid0_t1", dvalid0, 1'b1);
        check_output("lit_dout0",      dout0,   e0);
        check_output("lit_dvalid1_t1", dvalid1, 1'b0);
        idle();
        check_output("lit_dvalid0_t2", dvalid0, 1'b0);
        check_output("lit_dvalid1_t2", dvalid1, 1'b1);
        check_output("lit_dout1",      dout1,   e1);
    endtask

    initial begin
        rst = 1'b1; re = 1'b0; we = 1'b0;
        raddr = '0; waddr = '0; wbe = '0; din = '0;
        @(negedge clk);
        rst = 1'b0;
        measure_clear("por_clear", 1'b0);

        // Fill with all-ones, then reset while hammering requests during the clear.
        for (int a = 0; a < N; a++)
            apply_stimulus(1'b0, 1'b0, '0, 1'b1, AW'(a), 2'b11, 16'hFFFF);
        apply_stimulus(1'b1, 1'b0, '0, 1'b0, '0, 2'b00, '0);
        @(negedge clk);
        rst = 1'b0;
        measure_clear("gated_clear", 1'b1);

        // Back-to-back reads of every address: contiguous zeros.
        for (int a = 0; a < N; a++)
            apply_stimulus(1'b0, 1'b1, AW'(a), 1'b0, '0, 2'b00, '0);
        repeat (3) idle();
        read_check(4'd5, 16'h0000, 16'h0000);

        // Byte enables.
        apply_stimulus(1'b0, 1'b0, '0, 1'b1, 4'd3, 2'b11, 16'hA5A5);
        apply_stimulus(1'b0, 1'b0, '0, 1'b1, 4'd3, 2'b01, 16'h1234);
        read_check(4'd3, 16'hA534, 16'hA534);

        // Same-address read-during-write.
        apply_stimulus(1'b0, 1'b0, '0, 1'b1, 4'd7, 2'b11, 16'hBEEF);
        apply_stimulus(1'b0, 1'b1, 4'd7, 1'b1, 4'd7, 2'b10, 16'h1122);
        idle();
        check_output("bypass_dout0", dout0, 16'h11EF);
        idle();
        check_output("bypass_dout1", dout1, 16'hBEEF);
        read_check(4'd7, 16'h11EF, 16'h11EF);

        // Read, then reset next cycle: 2-cycle instance must drop it.
        apply_stimulus(1'b0, 1'b1, 4'd2, 1'b0, '0, 2'b00, '0);
        apply_stimulus(1'b1, 1'b0, '0, 1'b0, '0, 2'b00, '0);
        @(negedge clk);
        rst = 1'b0;
        check_output("rst_kill_dvalid1", dvalid1, 1'b0);
        measure_clear("midop_clear", 1'b0);

        // Reset at clear counter 9: a full new sweep follows.
        apply_stimulus(1'b1, 1'b0, '0, 1'b0, '0, 2'b00, '0);
        @(negedge clk);
        rst = 1'b0;
        repeat (9) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        measure_clear("restart_clear", 1'b0);

        // Random traffic, biased towards address collisions, rare resets.
        for (int i = 0; i < 1500; i++) begin
            logic [AW-1:0] wa;
            wa = AW'($urandom_range(0, N-1));
            apply_stimulus($urandom_range(0, 149) == 0,
                           1'($urandom_range(0, 1)),
                           ($urandom_range(0, 1) == 1) ? wa : AW'($urandom_range(0, N-1)),
                           1'($urandom_range(0, 1)),
                           wa,
                           2'($urandom_range(0, 3)),
                           DW'($urandom));
        end
        repeat (N + 4) idle();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/dpram_sclk_be.md
# dpram_sclk_be

Single-clock simple dual-port RAM (one read port, one write port) with per-byte write enables, selectable 1- or 2-cycle read latency, and read-during-write bypass with byte merge. It also has an optional hardware clear sequencer that zeroes every word after reset. It is the storage primitive under the SYNC_FIFO family and other on-chip buffers that need partial-word writes and a known post-reset memory state in silicon, not only in simulation.

## Interface
- ADDR_WIDTH, 9, address bits; depth N = 2^ADDR_WIDTH words
- DATA_WIDTH, 16, word width; must be an integer multiple of BYTE_WIDTH
- BYTE_WIDTH, 8, lane width; NB = DATA_WIDTH/BYTE_WIDTH lanes
- READ_LATENCY, 1, 1 or 2 cycles from re to dvalid; other values are illegal (elaboration error)
- ENABLE_BYPASS, 1, 1 = same-address read-during-write returns merged new data; 0 = returns old data
- CLEAR_ON_RESET, 1, 1 = hardware clear after reset; 0 = no clear, contents undefined after power-up
- clk  in  1  single clock; all logic on rising edge
- rst  in  1  synchronous, active-high reset
- raddr  in  ADDR_WIDTH  read address
- re  in  1  read request
- waddr  in  ADDR_WIDTH  write address
- we  in  1  write request
- wbe  in  NB  byte-lane write enables; lane i covers din[i*BYTE_WIDTH +: BYTE_WIDTH]
- din  in  DATA_WIDTH  write data
- dout  out  DATA_WIDTH  read data; 0 whenever dvalid=0
- dvalid  out  1  dout holds the result of a read accepted READ_LATENCY cycles earlier
- init_busy  out  1  clear in progress; re/we ignored while 1

## Operation
- Reset values: dout=0, dvalid=0, read pipeline flushed, init_busy=CLEAR_ON_RESET, clear counter=0. Memory contents are not touched by rst itself.
- Clear FSM (CLEAR_ON_RESET=1): states CLEAR, RUN.
  - rst forces CLEAR with counter 0.
  - In CLEAR with rst=0: each cycle writes 0 to mem[counter] (all lanes) and increments the counter.
  - After writing address N-1, the FSM moves to RUN.
  - init_busy = (state==CLEAR).
  - rst asserted mid-clear restarts the clear from address 0.
  - CLEAR_ON_RESET=0: FSM absent, init_busy tied 0.
- A request is accepted only when init_busy=0 and rst=0. Requests outside those conditions are dropped silently and produce no dvalid.
- Write: accepted we with wbe lane i set updates lane i of mem[waddr] at the clock edge. Lanes with wbe=0 are unchanged. we=1 with wbe=0 is a no-op.
- Read: accepted re captures mem[raddr] and produces one dvalid pulse READ_LATENCY cycles later. Back-to-back reads are sustained at one per cycle.
- Same cycle, raddr==waddr, both accepted:
  - ENABLE_BYPASS=1: returned word lane i = din lane i if wbe[i], else old lane i.
  - ENABLE_BYPASS=0: returned word is fully old data.
  - The write is performed in both cases.
- Different addresses in the same cycle are fully independent.
- A read in any cycle after a write completes sees the new data, regardless of bypass.
- READ_LATENCY=2: stage 1 holds the RAM/merged word; stage 2 is an output register. Both stages advance every cycle (no stall). dvalid is pipelined alongside the data.
- dout is gated to 0 when dvalid=0; no stale data is visible.

## Timing
- re at edge T (accepted) -> dvalid=1 and dout valid during cycle T+READ_LATENCY.
- we at edge T -> data observable by a read issued at edge T+1 (or at edge T via bypass).
- Clear timing: rst=1 sampled at edge E0, rst=0 at E1..EN writes addresses 0..N-1. init_busy falls after EN: exactly N cycles of busy after reset release.
- rst=1 at any edge:
  - dvalid and dout are 0 from the next cycle.
  - In-flight reads are discarded.
  - A write sampled in the same cycle as rst=1 is dropped.
- No combinational path from inputs to outputs; all outputs are registered or derived from registered state.

## Test plan
- Clear: ADDR_WIDTH=4, CLEAR_ON_RESET=1, preload mem with 0xFFFF, pulse rst 1 cycle -> init_busy high exactly 16 cycles; reads of addresses 0..15 then return 0x0000 with dvalid after READ_LATENCY.
- Byte enables: write 0xA5A5 to addr 3 with wbe=11, then 0x1234 with wbe=01 -> read addr 3 returns 0xA534.
- Bypass merge: mem[7]=0xBEEF; same cycle re/we addr 7, din=0x1122, wbe=10 -> ENABLE_BYPASS=1 returns 0x11EF; ENABLE_BYPASS=0 returns 0xBEEF; both configs then read 0x11EF next.
- Latency/throughput: READ_LATENCY=1 and 2, reads of addrs 0..5 on consecutive cycles -> 6 contiguous dvalid pulses, correct data, first pulse at +1 / +2 cycles.
- Busy gating: assert re/we throughout the clear sequence -> no dvalid, no writes land; all words still 0 after clear.
- Reset mid-operation: re issued, rst asserted in the next cycle with READ_LATENCY=2 -> no dvalid emitted. rst mid-clear at counter 9 -> clear restarts at 0 and init_busy lasts a further full 16 cycles.
